// File: rtl/round_scheduler.sv
// Batch sequencer for the number-baseball solver/grader pair: fetches an answer,
// pulses the game reset, waits for correct or the turn limit, reports and totals.
module round_scheduler #(
  parameter int NUM_ROUND  = 1024,
  parameter int ROUND_W    = 10,
  parameter int MAX_CNT    = 200,
  parameter int RST_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               ans_req,
  input  logic               ans_valid,
  input  logic [15:0]        ans_data,
  output logic [15:0]        answer,
  output logic               game_rst_n,
  input  logic               correct,
  input  logic [15:0]        cnt,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [ROUND_W-1:0] res_round,
  output logic [15:0]        res_cnt,
  output logic               res_timeout,
  output logic [31:0]        total_cnt,
  output logic [15:0]        num_timeouts,
  output logic               busy,
  output logic               done
);

  localparam int                 RC_W       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0]    RC_LAST    = RC_W'(RST_CYCLES - 1);
  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUND - 1);
  localparam logic [15:0]        CNT_LIMIT  = 16'(MAX_CNT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_GRST   = 3'd2,
    S_PLAY   = 3'd3,
    S_REPORT = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t             r_state;
  logic               r_ans_req;
  logic [15:0]        r_answer;
  logic               r_game_rst_n;
  logic               r_res_valid;
  logic [ROUND_W-1:0] r_round;
  logic [15:0]        r_res_cnt;
  logic               r_res_timeout;
  logic [31:0]        r_total_cnt;
  logic [15:0]        r_num_timeouts;
  logic               r_busy;
  logic               r_done;
  logic [RC_W-1:0]    r_rst_cnt;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [15:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {17'd0, b};
    if (sum[32]) begin
      return 32'hFFFF_FFFF;
    end else begin
      return sum[31:0];
    end
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] a, input logic inc);
    if (inc && (a != 16'hFFFF)) begin
      return a + 16'd1;
    end else begin
      return a;
    end
  endfunction

  // Round sequencing FSM with all outputs registered alongside the state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_ans_req      <= 1'b0;
      r_answer       <= 16'd0;
      r_game_rst_n   <= 1'b0;
      r_res_valid    <= 1'b0;
      r_round        <= '0;
      r_res_cnt      <= 16'd0;
      r_res_timeout  <= 1'b0;
      r_total_cnt    <= 32'd0;
      r_num_timeouts <= 16'd0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_rst_cnt      <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_game_rst_n <= 1'b0;
          if (start) begin
            r_total_cnt    <= 32'd0;
            r_num_timeouts <= 16'd0;
            r_round        <= '0;
            r_done         <= 1'b0;
            r_busy         <= 1'b1;
            r_ans_req      <= 1'b1;
            r_state        <= S_FETCH;
          end
        end
        // game_rst_n keeps its last value here so the low pulse starts at acceptance
        S_FETCH: begin
          if (ans_valid && r_ans_req) begin
            r_answer     <= ans_data;
            r_rst_cnt    <= '0;
            r_ans_req    <= 1'b0;
            r_game_rst_n <= 1'b0;
            r_state      <= S_GRST;
          end
        end
        S_GRST: begin
          if (r_rst_cnt == RC_LAST) begin
            r_game_rst_n <= 1'b1;
            r_state      <= S_PLAY;
          end else begin
            r_rst_cnt <= r_rst_cnt + RC_W'(1);
          end
        end
        S_PLAY: begin
          if (correct) begin
            r_res_cnt     <= cnt;
            r_res_timeout <= 1'b0;
            r_res_valid   <= 1'b1;
            r_state       <= S_REPORT;
          end else if (cnt >= CNT_LIMIT) begin
            r_res_cnt     <= cnt;
            r_res_timeout <= 1'b1;
            r_res_valid   <= 1'b1;
            r_state       <= S_REPORT;
          end
        end
        // Totals move only when the sink takes the result
        S_REPORT: begin
          if (res_ready) begin
            r_res_valid    <= 1'b0;
            r_total_cnt    <= sat_add32(r_total_cnt, r_res_cnt);
            r_num_timeouts <= sat_inc16(r_num_timeouts, r_res_timeout);
            if (r_round == LAST_ROUND) begin
              r_done       <= 1'b1;
              r_busy       <= 1'b0;
              r_game_rst_n <= 1'b0;
              r_state      <= S_DONE;
            end else begin
              r_round   <= r_round + ROUND_W'(1);
              r_ans_req <= 1'b1;
              r_state   <= S_FETCH;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ans_req      = r_ans_req;
  assign answer       = r_answer;
  assign game_rst_n   = r_game_rst_n;
  assign res_valid    = r_res_valid;
  assign res_round    = r_round;
  assign res_cnt      = r_res_cnt;
  assign res_timeout  = r_res_timeout;
  assign total_cnt    = r_total_cnt;
  assign num_timeouts = r_num_timeouts;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule

// File: tb/tb_round_scheduler.sv
// Bench for round_scheduler: emulates the answer source, a counting grader and
// the result sink cycle by cycle, and checks each scenario against the round rules.
module tb_round_scheduler;

  localparam int NR = 2;
  localparam int RW = 2;
  localparam int MAXC = 200;

  logic          clk, reset, start;
  logic          ans_req, ans_valid;
  logic [15:0]   ans_data, answer;
  logic          game_rst_n, correct;
  logic [15:0]   cnt;
  logic          res_valid, res_ready;
  logic [RW-1:0] res_round;
  logic [15:0]   res_cnt;
  logic          res_timeout;
  logic [31:0]   total_cnt;
  logic [15:0]   num_timeouts;
  logic          busy, done;

  int checks = 0;
  int failures = 0;
  int g = 0;

  typedef struct {
    logic [15:0]   cnt;
    logic          to;
    logic [RW-1:0] rnd;
    int            req_cycles;
    int            low_cycles;
    int            valid_cycles;
    logic [15:0]   exp_ans;
    bit            ans_ok;
    bit            hold_ok;
    bit            got;
  } obs_t;

  round_scheduler #(.NUM_ROUND(NR), .ROUND_W(RW), .MAX_CNT(MAXC), .RST_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .start(start), .ans_req(ans_req), .ans_valid(ans_valid),
    .ans_data(ans_data), .answer(answer), .game_rst_n(game_rst_n), .correct(correct),
    .cnt(cnt), .res_valid(res_valid), .res_ready(res_ready), .res_round(res_round),
    .res_cnt(res_cnt), .res_timeout(res_timeout), .total_cnt(total_cnt),
    .num_timeouts(num_timeouts), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Expected result of a round whose grader would say correct at turn 'target'
  function automatic int exp_cnt(input int target);
    return (target > MAXC) ? MAXC : target;
  endfunction

  function automatic bit exp_to(input int target);
    return target > MAXC;
  endfunction

  task automatic kick();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Plays one round from the current negedge; abort_at>=0 pulls reset that many PLAY cycles in
  task automatic play_round(input int target, input int delay, input int stall,
                            input int abort_at, output obs_t o);
    int req_cnt = 0, stall_cnt = 0, play_cyc = 0;
    bit accepted = 0, drove_valid = 0, played = 0, seen_valid = 0, ready_drv = 0;
    logic [31:0] tot0 = 32'd0;
    o.cnt = 16'd0; o.to = 1'b0; o.rnd = '0; o.req_cycles = 0; o.low_cycles = 0;
    o.valid_cycles = 0; o.exp_ans = 16'd0; o.ans_ok = 1; o.hold_ok = 1; o.got = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (ready_drv) begin
        res_ready = 1'b0;
        o.got = 1;
        return;
      end
      if (drove_valid) begin
        accepted = 1;
        drove_valid = 0;
      end
      if (!game_rst_n) g = 0;
      else if (g != target && g < MAXC) g = g + 1;
      cnt = 16'(g);
      correct = (g == target);
      if (accepted && !played) begin
        if (!game_rst_n) o.low_cycles++;
        else played = 1;
      end
      if (accepted && answer !== o.exp_ans) o.ans_ok = 0;
      if (played) begin
        play_cyc++;
        if (abort_at >= 0 && play_cyc > abort_at) begin
          reset = 1'b0;
          ans_valid = 1'b0;
          o.got = 1;
          return;
        end
      end
      if (ans_req) begin
        if (req_cnt == delay) begin
          ans_valid = 1'b1;
          ans_data = 16'($urandom);
          o.exp_ans = ans_data;
          drove_valid = 1;
        end else begin
          ans_valid = 1'b0;
        end
        req_cnt++;
      end else begin
        ans_valid = 1'b0;
      end
      o.req_cycles = req_cnt;
      if (res_valid) begin
        if (!seen_valid) begin
          seen_valid = 1;
          o.cnt = res_cnt; o.to = res_timeout; o.rnd = res_round; tot0 = total_cnt;
        end else if (res_cnt !== o.cnt || res_timeout !== o.to || res_round !== o.rnd ||
                     total_cnt !== tot0) begin
          o.hold_ok = 0;
        end
        if (ans_req) o.hold_ok = 0;
        o.valid_cycles++;
        if (stall_cnt < stall) begin
          res_ready = 1'b0;
          stall_cnt++;
        end else begin
          res_ready = 1'b1;
          ready_drv = 1;
        end
      end else begin
        res_ready = 1'b0;
      end
      @(negedge clk);
    end
    res_ready = 1'b0;
    ans_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if ({ans_req, answer, game_rst_n, res_valid, res_round} !== '0) begin
      failures++; $display("FAIL reset_ctl got=%h exp=0", {ans_req, answer, game_rst_n, res_valid, res_round}); end
    checks++; if ({res_cnt, res_timeout, total_cnt, num_timeouts, busy, done} !== '0) begin
      failures++; $display("FAIL reset_data got=%h exp=0", {res_cnt, res_timeout, total_cnt, num_timeouts, busy, done}); end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({ans_req, busy, game_rst_n} !== 3'b000) begin
      failures++; $display("FAIL reset_idle got=%b exp=000", {ans_req, busy, game_rst_n}); end
  endtask

  task automatic test_basic();
    obs_t o;
    kick();
    checks++; if ({ans_req, busy} !== 2'b11) begin
      failures++; $display("FAIL basic_req_latency got=%b exp=11", {ans_req, busy}); end
    play_round(5, 1, 0, -1, o);
    checks++; if ({o.got, o.rnd, o.cnt, o.to} !== {1'b1, 2'd0, 16'd5, 1'b0}) begin
      failures++; $display("FAIL basic_r0 got=%0d/%0d/%0d/%0d exp=1/0/5/0", o.got, o.rnd, o.cnt, o.to); end
    checks++; if ({o.ans_ok, o.low_cycles} !== {1'b1, 32'd2}) begin
      failures++; $display("FAIL basic_grst got=%0d/%0d exp=1/2", o.ans_ok, o.low_cycles); end
    play_round(7, 1, 0, -1, o);
    checks++; if ({o.got, o.rnd, o.cnt, o.to} !== {1'b1, 2'd1, 16'd7, 1'b0}) begin
      failures++; $display("FAIL basic_r1 got=%0d/%0d/%0d/%0d exp=1/1/7/0", o.got, o.rnd, o.cnt, o.to); end
    checks++; if (total_cnt !== 32'd12) begin
      failures++; $display("FAIL basic_total got=%0d exp=12", total_cnt); end
    checks++; if ({done, busy, res_valid, game_rst_n} !== 4'b1000) begin
      failures++; $display("FAIL basic_done got=%b exp=1000", {done, busy, res_valid, game_rst_n}); end
  endtask

  task automatic test_timeout();
    obs_t o;
    kick();
    play_round(300, 0, 0, -1, o);
    checks++; if ({o.got, o.cnt, o.to} !== {1'b1, 16'd200, 1'b1}) begin
      failures++; $display("FAIL timeout_r0 got=%0d/%0d/%0d exp=1/200/1", o.got, o.cnt, o.to); end
    play_round(4, 0, 0, -1, o);
    checks++; if ({num_timeouts, total_cnt} !== {16'd1, 32'd204}) begin
      failures++; $display("FAIL timeout_totals got=%0d/%0d exp=1/204", num_timeouts, total_cnt); end
  endtask

  task automatic test_tie();
    obs_t o;
    kick();
    play_round(200, 0, 0, -1, o);
    checks++; if ({o.got, o.cnt, o.to} !== {1'b1, 16'd200, 1'b0}) begin
      failures++; $display("FAIL tie_r0 got=%0d/%0d/%0d exp=1/200/0", o.got, o.cnt, o.to); end
    play_round(1, 0, 0, -1, o);
    checks++; if ({num_timeouts, total_cnt} !== {16'd0, 32'd201}) begin
      failures++; $display("FAIL tie_totals got=%0d/%0d exp=0/201", num_timeouts, total_cnt); end
  endtask

  task automatic test_back_to_back_backpressure();
    obs_t o;
    kick();
    play_round(6, 0, 3, -1, o);
    checks++; if ({o.got, o.valid_cycles, o.hold_ok} !== {1'b1, 32'd4, 1'b1}) begin
      failures++; $display("FAIL bp_hold got=%0d/%0d/%0d exp=1/4/1", o.got, o.valid_cycles, o.hold_ok); end
    checks++; if ({total_cnt, res_valid, ans_req} !== {32'd6, 1'b0, 1'b1}) begin
      failures++; $display("FAIL bp_accept got=%0d/%0d/%0d exp=6/0/1", total_cnt, res_valid, ans_req); end
    play_round(2, 0, 1, -1, o);
    checks++; if ({total_cnt, done} !== {32'd8, 1'b1}) begin
      failures++; $display("FAIL bp_total got=%0d/%0d exp=8/1", total_cnt, done); end
  endtask

  task automatic test_ans_delay();
    obs_t o;
    kick();
    play_round(3, 5, 0, -1, o);
    checks++; if ({o.got, o.req_cycles, o.low_cycles, o.ans_ok} !== {1'b1, 32'd6, 32'd2, 1'b1}) begin
      failures++; $display("FAIL delay_r0 got=%0d/%0d/%0d/%0d exp=1/6/2/1", o.got, o.req_cycles, o.low_cycles, o.ans_ok); end
    play_round(3, 0, 0, -1, o);
    checks++; if ({o.req_cycles, o.low_cycles, o.ans_ok} !== {32'd1, 32'd2, 1'b1}) begin
      failures++; $display("FAIL delay_r1 got=%0d/%0d/%0d exp=1/2/1", o.req_cycles, o.low_cycles, o.ans_ok); end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    kick();
    play_round(4, 0, 0, -1, o);
    play_round(50, 0, 0, 3, o);
    #1;
    checks++; if ({ans_req, answer, game_rst_n, res_valid, res_round, res_cnt, res_timeout} !== '0) begin
      failures++; $display("FAIL midrst_ctl got=%h exp=0", {ans_req, answer, game_rst_n, res_valid, res_round, res_cnt, res_timeout}); end
    checks++; if ({total_cnt, num_timeouts, busy, done} !== '0) begin
      failures++; $display("FAIL midrst_data got=%h exp=0", {total_cnt, num_timeouts, busy, done}); end
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if ({res_valid, ans_req, busy} !== 3'b000) begin
      failures++; $display("FAIL midrst_idle got=%b exp=000", {res_valid, ans_req, busy}); end
    kick();
    play_round(9, 1, 0, -1, o);
    checks++; if ({o.got, o.rnd, o.cnt} !== {1'b1, 2'd0, 16'd9}) begin
      failures++; $display("FAIL midrst_restart got=%0d/%0d/%0d exp=1/0/9", o.got, o.rnd, o.cnt); end
    play_round(2, 0, 0, -1, o);
    checks++; if ({total_cnt, done} !== {32'd11, 1'b1}) begin
      failures++; $display("FAIL midrst_total got=%0d/%0d exp=11/1", total_cnt, done); end
  endtask

  task automatic test_random();
    obs_t o;
    for (int b = 0; b < 4; b++) begin
      int tot = 0, tos = 0;
      kick();
      for (int r = 0; r < NR; r++) begin
        int t = int'($urandom_range(230, 1));
        int d = int'($urandom_range(3, 0));
        int s = int'($urandom_range(2, 0));
        play_round(t, d, s, -1, o);
        tot += exp_cnt(t);
        tos += int'(exp_to(t));
        checks++;
        if ({o.got, o.rnd, o.cnt, o.to, o.hold_ok, o.ans_ok} !==
            {1'b1, RW'(r), 16'(exp_cnt(t)), exp_to(t), 1'b1, 1'b1}) begin
          failures++;
          $display("FAIL rand_b%0d_r%0d got=%0d/%0d/%0d/%0d/%0d/%0d exp=1/%0d/%0d/%0d/1/1", b, r,
                   o.got, o.rnd, o.cnt, o.to, o.hold_ok, o.ans_ok, r, exp_cnt(t), exp_to(t));
        end
      end
      checks++;
      if ({total_cnt, num_timeouts, done, busy} !== {32'(tot), 16'(tos), 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL rand_b%0d_totals got=%0d/%0d/%0d/%0d exp=%0d/%0d/1/0", b,
                 total_cnt, num_timeouts, done, busy, tot, tos);
      end
    end
  endtask

  initial begin
    clk = 1'b0; reset = 1'b0; start = 1'b0; ans_valid = 1'b0; ans_data = 16'd0;
    correct = 1'b0; cnt = 16'd0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_basic();
    test_timeout();
    test_tie();
    test_back_to_back_backpressure();
    test_ans_delay();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/round_scheduler.md
Name: round_scheduler

Overview:
- Sequences the number-baseball datapath (solver + grader pair) across a batch of rounds.
- Per round: fetches an answer from an answer source, drives it to the grader, holds solver/grader in reset, then releases them and waits for `correct` or the turn-limit timeout.
- Reports each round's count on a valid/ready result port and keeps batch totals (total turns, timeouts).
- Sits between the answer memory, the solver/grader pair and a result sink/logger.

Parameters:
- NUM_ROUND, 1024, rounds per batch (>=1).
- ROUND_W, 10, width of round index; must satisfy 2^ROUND_W >= NUM_ROUND.
- MAX_CNT, 200, turn limit; round ends as timeout when grader cnt >= MAX_CNT.
- RST_CYCLES, 2, cycles game_rst_n is held low per round (>=1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous active-low reset.
- start  in  1  begin batch; sampled only in IDLE or DONE.
- ans_req  out  1  answer request, held high until ans_valid.
- ans_valid  in  1  answer data valid; qualified by ans_req.
- ans_data  in  16  answer from answer source.
- answer  out  16  registered answer driven to grader.
- game_rst_n  out  1  active-low reset to solver and grader.
- correct  in  1  grader correct flag.
- cnt  in  16  grader turn count.
- res_valid  out  1  round result valid.
- res_ready  in  1  result sink ready.
- res_round  out  ROUND_W  index of reported round.
- res_cnt  out  16  captured cnt of reported round.
- res_timeout  out  1  reported round hit MAX_CNT without correct.
- total_cnt  out  32  sum of accepted res_cnt, saturating at 2^32-1.
- num_timeouts  out  16  accepted timeout rounds, saturating.
- busy  out  1  high in every state except IDLE/DONE.
- done  out  1  high in DONE.

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE.
  - All outputs 0, including game_rst_n=0 (game held in reset).
  - Counters and round index cleared.
  - Reset mid-round aborts the round; no result is emitted.
- States: IDLE, FETCH, GRST, PLAY, REPORT, DONE.
- IDLE and DONE:
  - game_rst_n=0.
  - start=1 clears total_cnt, num_timeouts and round index, and clears done; next state is FETCH.
  - start is ignored in all other states.
- FETCH:
  - ans_req=1.
  - On ans_valid=1: answer<=ans_data, rst counter<=0, next state GRST.
  - ans_req drops the cycle after acceptance.
  - Start to ans_req latency is 1 cycle.
- GRST:
  - game_rst_n=0 for exactly RST_CYCLES cycles; the first low cycle is the one after ans_valid acceptance.
  - Then go to PLAY.
  - answer is stable from GRST entry until the next FETCH acceptance.
- PLAY:
  - game_rst_n=1.
  - Each cycle:
    - If correct=1: res_cnt<=cnt, res_timeout<=0, go to REPORT.
    - Else if cnt>=MAX_CNT: res_cnt<=cnt, res_timeout<=1, go to REPORT.
  - correct has priority when both hold in the same cycle.
  - correct is level-sampled; it is guaranteed low on entry because of GRST.
- REPORT:
  - game_rst_n stays 1 (grader holds its final state).
  - res_valid=1; res_round, res_cnt and res_timeout are stable while res_valid=1 and res_ready=0.
  - On res_valid&&res_ready:
    - total_cnt += res_cnt (saturating).
    - num_timeouts += res_timeout (saturating).
    - res_valid drops next cycle.
    - If res_round==NUM_ROUND-1, go to DONE; else round index +1 and go to FETCH.
- Counters update only on result acceptance, never at capture.
- res_round reflects the current round index from FETCH onward.
- With NUM_ROUND=1, the first accepted result goes to DONE.
- done stays high until the next start or reset. total_cnt and num_timeouts remain readable in DONE.

Test Plan:
- NUM_ROUND=2, ans_valid returned 1 cycle after ans_req, correct rises at cnt=5 then cnt=7, res_ready=1 → two results {round 0, cnt 5, to 0} and {round 1, cnt 7, to 0}; total_cnt=12; done=1; busy=0.
- correct never asserted, cnt ramps to 200 → res_cnt=200, res_timeout=1, num_timeouts=1.
- correct=1 and cnt=200 in the same cycle → res_timeout=0, res_cnt=200.
- res_ready held low 3 cycles in REPORT → res_valid and payload held stable 4 cycles; total_cnt updates once; no FETCH until accepted.
- ans_valid delayed 5 cycles; RST_CYCLES=2 → ans_req high 6 cycles; game_rst_n low exactly 2 cycles after acceptance; answer equals ans_data.
- reset asserted in PLAY of round 1 → all outputs 0 immediately; state IDLE; no result; a new start restarts at round 0 with total_cnt=0.
